spi_debug_bridge: RTL

//  Parametrised SPI command bridge between the spi_target byte stream and the RISC-V core.

---
 rtl/spi_debug_bridge.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/spi_debug_bridge.sv
// SPI command bridge: decodes spi_target bytes into core halt/run/step control,
// IMEM/DMEM writes, DMEM readback over MISO and a status byte.
module spi_debug_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter bit RESET_HALT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ss_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic              o_mem_dsel,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_rvalid,
    output logic              o_cpu_halt,
    output logic              o_cpu_step,
    input  logic [31:0]       i_debug_pc,
    output logic              o_err,
    output logic [3:0]        dbg_state
);

    localparam int ABYTES = ADDR_W / 8;
    localparam int DBYTES = DATA_W / 8;
    localparam int SW     = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    localparam logic [7:0] CMD_STOP     = 8'h10;
    localparam logic [7:0] CMD_RUN      = 8'h11;
    localparam logic [7:0] CMD_STEP     = 8'h12;
    localparam logic [7:0] CMD_SET_ADDR = 8'h20;
    localparam logic [7:0] CMD_WR_IMEM  = 8'h30;
    localparam logic [7:0] CMD_WR_DMEM  = 8'h31;
    localparam logic [7:0] CMD_RD_DMEM  = 8'h40;
    localparam logic [7:0] CMD_STATUS   = 8'h50;
    localparam logic [7:0] CMD_CLR_ERR  = 8'h51;

    typedef enum logic [3:0] {
        S_CMD      = 4'd0,
        S_ARG      = 4'd1,
        S_RD_WAIT  = 4'd2,
        S_RD_SHIFT = 4'd3
    } state_t;

    // Handshake: a byte is taken on any cycle with i_rx_valid high while i_ss_n is low;
    // there is no back-pressure. i_mem_rvalid is accepted only while waiting for a read.
    state_t            state, state_n;
    logic [7:0]        cmd;
    logic [7:0]        cnt;
    logic [SW-1:0]     arg_sr, arg_next;
    logic [DATA_W-1:0] rd_buf, rd_next;
    logic              rd_drop;
    logic              rx_ok, arg_last, rd_last, drop_now;
    logic              unused_pc;

    assign rx_ok     = i_rx_valid & ~i_ss_n;
    assign arg_next  = (arg_sr << 8) | SW'(i_rx_data);
    assign rd_next   = rd_buf << 8;
    assign arg_last  = (cnt == ((cmd == CMD_SET_ADDR) ? 8'(ABYTES - 1) : 8'(DBYTES - 1)));
    assign rd_last   = (cnt == 8'(DBYTES - 1));
    assign drop_now  = rd_drop | i_ss_n;
    assign dbg_state = state;
    assign unused_pc = ^i_debug_pc[31:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_CMD;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_CMD: begin
                if (rx_ok) begin
                    if (i_rx_data == CMD_SET_ADDR || i_rx_data == CMD_WR_IMEM ||
                        i_rx_data == CMD_WR_DMEM)
                        state_n = S_ARG;
                    else if (i_rx_data == CMD_RD_DMEM)
                        state_n = S_RD_WAIT;
                end
            end
            S_ARG: begin
                if (i_ss_n)                  state_n = S_CMD;
                else if (rx_ok && arg_last)  state_n = S_CMD;
            end
            S_RD_WAIT: begin
                if (i_mem_rvalid) state_n = drop_now ? S_CMD : S_RD_SHIFT;
            end
            S_RD_SHIFT: begin
                if (i_ss_n)                 state_n = S_CMD;
                else if (rx_ok && rd_last)  state_n = S_CMD;
            end
            default: state_n = S_CMD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd         <= '0;
            cnt         <= '0;
            arg_sr      <= '0;
            rd_buf      <= '0;
            rd_drop     <= 1'b0;
            o_tx_data   <= 8'h00;
            o_mem_we    <= 1'b0;
            o_mem_re    <= 1'b0;
            o_mem_dsel  <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_cpu_halt  <= RESET_HALT;
            o_cpu_step  <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_mem_we   <= 1'b0;
            o_mem_re   <= 1'b0;
            o_cpu_step <= 1'b0;
            // Post-write increment lands the cycle after the strobe so addr is stable with we.
            if (o_mem_we) o_mem_addr <= o_mem_addr + ADDR_W'(DBYTES);
            case (state)
                S_CMD: begin
                    if (rx_ok) begin
                        cmd       <= i_rx_data;
                        cnt       <= '0;
                        arg_sr    <= '0;
                        o_tx_data <= i_debug_pc[7:0];
                        case (i_rx_data)
                            CMD_STOP:     o_cpu_halt <= 1'b1;
                            CMD_RUN:      o_cpu_halt <= 1'b0;
                            CMD_STEP: begin
                                if (o_cpu_halt) o_cpu_step <= 1'b1;
                                else            o_err      <= 1'b1;
                            end
                            CMD_SET_ADDR, CMD_WR_IMEM, CMD_WR_DMEM: ;
                            CMD_RD_DMEM: begin
                                o_mem_re   <= 1'b1;
                                o_mem_dsel <= 1'b1;
                                rd_drop    <= 1'b0;
                                o_tx_data  <= o_tx_data;
                            end
                            CMD_STATUS:   o_tx_data <= {o_err, ~o_cpu_halt, 2'b00, state};
                            CMD_CLR_ERR:  o_err <= 1'b0;
                            default:      o_err <= 1'b1;
                        endcase
                    end
                end
                S_ARG: begin
                    if (rx_ok) begin
                        arg_sr <= arg_next;
                        cnt    <= cnt + 8'd1;
                        if (arg_last) begin
                            if (cmd == CMD_SET_ADDR) begin
                                o_mem_addr <= arg_next[ADDR_W-1:0];
                            end else if (cmd == CMD_WR_IMEM && !o_cpu_halt) begin
                                o_err <= 1'b1;
                            end else begin
                                o_mem_we    <= 1'b1;
                                o_mem_dsel  <= (cmd == CMD_WR_DMEM);
                                o_mem_wdata <= arg_next[DATA_W-1:0];
                            end
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (i_ss_n)          rd_drop <= 1'b1;
                    else if (i_rx_valid) o_err   <= 1'b1;
                    if (i_mem_rvalid && !drop_now) begin
                        rd_buf    <= i_mem_rdata;
                        o_tx_data <= i_mem_rdata[DATA_W-1 -: 8];
                        cnt       <= '0;
                    end
                end
                S_RD_SHIFT: begin
                    if (rx_ok) begin
                        cnt <= cnt + 8'd1;
                        if (rd_last) begin
                            o_mem_addr <= o_mem_addr + ADDR_W'(DBYTES);
                            o_tx_data  <= i_debug_pc[7:0];
                        end else begin
                            rd_buf    <= rd_next;
                            o_tx_data <= rd_next[DATA_W-1 -: 8];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
